// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-cache controller.
// Takes the EXE/MEM latch outputs, issues one dcache read or write per
// memory instruction and holds the pipeline frozen until the access is done.
// Load data is aligned and then sign- or zero-extended. Store data is shifted
// into its byte lanes, and the matching byte enables are generated.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   dREN_mem/dWEN_mem  load/store request from the EXE/MEM latch
//   aluout_mem         effective byte address
//   rdata2_mem         store data, held in the low bits
//   funct3_mem         access size and signedness
//   dmemREN/dmemWEN    dcache request, held until dhit
//   dmemaddr           dword-aligned dcache address
//   dmemstore          store data shifted into its byte lanes
//   dmembyteen         store byte enables
//   dmemload, dhit     dcache read data and completion
//   freeze             stall to the upstream pipeline latches
//   mem_load_data      extended load result
//   mem_done           one-cycle pulse when the access completes
//   stall_cnt          saturating count of frozen cycles
//
// Optional build macro MISALIGN_TRAP_EN:
//   When it is defined, a misaligned access goes straight to DONE without a
//   dcache request, and misalign_trap is raised for that cycle.
//   When it is undefined, the offset is rounded down to natural alignment.
module mem_stage_ctrl #(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   dREN_mem,
    input  logic                   dWEN_mem,
    input  logic [63:0]            aluout_mem,
    input  logic [63:0]            rdata2_mem,
    input  logic [2:0]             funct3_mem,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic [63:0]            dmemaddr,
    output logic [63:0]            dmemstore,
    output logic [7:0]             dmembyteen,
    input  logic [63:0]            dmemload,
    input  logic                   dhit,
    output logic                   freeze,
    output logic [63:0]            mem_load_data,
    output logic                   mem_done,
`ifdef MISALIGN_TRAP_EN
    output logic                   misalign_trap,
`endif
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic                   ren_q, ren_d, wen_q, wen_d;
    logic [63:0]            addr_q, addr_d, store_q, store_d, data_q, data_d;
    logic [7:0]             byteen_q, byteen_d;
    logic [2:0]             f3_q, f3_d, off_q, off_d;
    logic                   trap_q, trap_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]  size_m1, off_raw, off_eff;
    logic [7:0]  lane_en;
    logic [63:0] store_raw, load_shift, load_ext;

    // Size decode for the incoming instruction (funct3 111 falls into the D case)
    always_comb begin
        off_raw = aluout_mem[2:0];
        case (funct3_mem[1:0])
            2'b00: begin size_m1 = 3'd0; lane_en = 8'h01; store_raw = {56'd0, rdata2_mem[7:0]};  end
            2'b01: begin size_m1 = 3'd1; lane_en = 8'h03; store_raw = {48'd0, rdata2_mem[15:0]}; end
            2'b10: begin size_m1 = 3'd3; lane_en = 8'h0F; store_raw = {32'd0, rdata2_mem[31:0]}; end
            default: begin size_m1 = 3'd7; lane_en = 8'hFF; store_raw = rdata2_mem;            end
        endcase
        // Misaligned offsets are rounded down; the trap build never issues them
        off_eff = off_raw & ~size_m1;
    end

    // Load extraction from the registered size and offset
    always_comb begin
        load_shift = dmemload >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {56'd0, load_shift[7:0]}  : {{56{load_shift[7]}},  load_shift[7:0]};
            2'b01:   load_ext = f3_q[2] ? {48'd0, load_shift[15:0]} : {{48{load_shift[15]}}, load_shift[15:0]};
            2'b10:   load_ext = f3_q[2] ? {32'd0, load_shift[31:0]} : {{32{load_shift[31]}}, load_shift[31:0]};
            default: load_ext = load_shift;
        endcase
    end

    // Next-state, freeze/done decode and stall counter
    always_comb begin
        state_d  = state_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        byteen_d = byteen_q;
        f3_d     = f3_q;
        off_d    = off_q;
        data_d   = data_q;
        trap_d   = trap_q;
        cnt_d    = cnt_q;
        freeze   = 1'b0;
        mem_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dREN_mem || dWEN_mem) begin
                    freeze   = 1'b1;
                    state_d  = S_REQ;
                    addr_d   = {aluout_mem[63:3], 3'b000};
                    f3_d     = funct3_mem;
                    off_d    = off_eff;
                    // A simultaneous load and store is treated as a store
                    ren_d    = dREN_mem & ~dWEN_mem;
                    wen_d    = dWEN_mem;
                    store_d  = dWEN_mem ? (store_raw << {off_eff, 3'b000}) : 64'd0;
                    byteen_d = dWEN_mem ? (lane_en << off_eff) : 8'd0;
`ifdef MISALIGN_TRAP_EN
                    if ((off_raw & size_m1) != 3'd0) begin
                        state_d  = S_DONE;
                        ren_d    = 1'b0;
                        wen_d    = 1'b0;
                        store_d  = 64'd0;
                        byteen_d = 8'd0;
                        data_d   = 64'd0;
                        trap_d   = 1'b1;
                    end
`endif
                end
            end
            S_REQ: begin
                freeze = 1'b1;
                // Once issued, the cache transaction always runs to dhit
                if (dhit) begin
                    if (ren_q) data_d = load_ext;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                mem_done = 1'b1;
                trap_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (freeze && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= 64'd0;
            store_q  <= 64'd0;
            byteen_q <= 8'd0;
            f3_q     <= 3'd0;
            off_q    <= 3'd0;
            data_q   <= 64'd0;
            trap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            byteen_q <= byteen_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            data_q   <= data_d;
            trap_q   <= trap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dmemREN       = ren_q;
    assign dmemWEN       = wen_q;
    assign dmemaddr      = addr_q;
    assign dmemstore     = store_q;
    assign dmembyteen    = byteen_q;
    assign mem_load_data = data_q;
    assign stall_cnt     = cnt_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`else
    logic unused_trap;
    assign unused_trap = trap_q ^ (|size_m1) ^ (|off_raw);
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl. Inputs are driven at the falling edge,
// and outputs are checked 1 time unit later.
module tb_mem_stage_ctrl;

    logic        CLK, nRST;
    logic        dREN_mem, dWEN_mem;
    logic [63:0] aluout_mem, rdata2_mem;
    logic [2:0]  funct3_mem;
    logic        dmemREN, dmemWEN;
    logic [63:0] dmemaddr, dmemstore;
    logic [7:0]  dmembyteen;
    logic [63:0] dmemload;
    logic        dhit, freeze, mem_done;
    logic [63:0] mem_load_data;
    logic [31:0] stall_cnt;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(.STALL_CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem),
        .aluout_mem(aluout_mem), .rdata2_mem(rdata2_mem), .funct3_mem(funct3_mem),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmembyteen(dmembyteen),
        .dmemload(dmemload), .dhit(dhit), .freeze(freeze),
        .mem_load_data(mem_load_data), .mem_done(mem_done),
`ifdef MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
`endif
        .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic do_reset();
        nRST = 1'b0; dREN_mem = 0; dWEN_mem = 0; aluout_mem = '0; rdata2_mem = '0;
        funct3_mem = '0; dmemload = '0; dhit = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        nRST = 1'b0;
        #1;
        checks++; if ({dmemREN, dmemWEN, freeze, mem_done} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000", {dmemREN, dmemWEN, freeze, mem_done}); end
        checks++; if (dmembyteen !== 8'h00) begin errors++; $display("FAIL reset_byteen: got %h expected 00", dmembyteen); end
        checks++; if (mem_load_data !== 64'd0) begin errors++; $display("FAIL reset_load: got %h expected 0", mem_load_data); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        checks++; if ({dmemaddr, dmemstore} !== 128'd0) begin errors++; $display("FAIL reset_addr_store: got %h expected 0", {dmemaddr, dmemstore}); end
        @(negedge CLK); nRST = 1'b1;
    endtask

    task automatic test_lb();
        do_reset();
        dREN_mem = 1; aluout_mem = 64'h1003; funct3_mem = 3'b000;
        #1;
        checks++; if ({freeze, dmemREN} !== 2'b10) begin errors++; $display("FAIL lb_c1 freeze/ren: got %b expected 10", {freeze, dmemREN}); end
        @(negedge CLK); dhit = 1; dmemload = 64'h00000000_80000000; #1;
        checks++; if ({freeze, dmemREN} !== 2'b11) begin errors++; $display("FAIL lb_c2 freeze/ren: got %b expected 11", {freeze, dmemREN}); end
        checks++; if (dmemaddr !== 64'h1000) begin errors++; $display("FAIL lb_addr: got %h expected 1000", dmemaddr); end
        checks++; if (dmembyteen !== 8'h00) begin errors++; $display("FAIL lb_byteen: got %h expected 00", dmembyteen); end
        @(negedge CLK); dhit = 0; #1;
        checks++; if ({freeze, mem_done, dmemREN} !== 3'b010) begin errors++; $display("FAIL lb_c3 freeze/done/ren: got %b expected 010", {freeze, mem_done, dmemREN}); end
        checks++; if (mem_load_data !== 64'hFFFFFFFF_FFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffffffffffff80", mem_load_data); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lb_cnt: got %0d expected 2", stall_cnt); end
        dREN_mem = 0;
        @(negedge CLK); #1;
        checks++; if ({freeze, mem_done} !== 2'b00) begin errors++; $display("FAIL lb_after: got %b expected 00", {freeze, mem_done}); end
    endtask

    task automatic test_lhu_wait();
        int held;
        held = 0;
        do_reset();
        dREN_mem = 1; aluout_mem = 64'h2006; funct3_mem = 3'b101; dmemload = 64'hBEEF0000_00000000;
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); dhit = (i == 4); #1;
            if (dmemREN === 1'b1) held++;
        end
        checks++; if (held !== 5) begin errors++; $display("FAIL lhu_ren_held: got %0d expected 5", held); end
        @(negedge CLK); dhit = 0; #1;
        checks++; if ({mem_done, dmemREN} !== 2'b10) begin errors++; $display("FAIL lhu_done/ren: got %b expected 10", {mem_done, dmemREN}); end
        checks++; if (mem_load_data !== 64'h0000_0000_0000_BEEF) begin errors++; $display("FAIL lhu_data: got %h expected beef", mem_load_data); end
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL lhu_cnt: got %0d expected 6", stall_cnt); end
        dREN_mem = 0;
        @(negedge CLK);
    endtask

    task automatic test_sw();
        do_reset();
        dWEN_mem = 1; aluout_mem = 64'h3004; funct3_mem = 3'b010; rdata2_mem = 64'h11223344_DEADBEEF;
        @(negedge CLK); #1;
        checks++; if ({dmemWEN, dmemREN} !== 2'b10) begin errors++; $display("FAIL sw_wen/ren: got %b expected 10", {dmemWEN, dmemREN}); end
        checks++; if (dmemstore !== 64'hDEADBEEF_00000000) begin errors++; $display("FAIL sw_store: got %h expected deadbeef00000000", dmemstore); end
        checks++; if (dmembyteen !== 8'hF0) begin errors++; $display("FAIL sw_byteen: got %h expected f0", dmembyteen); end
        @(negedge CLK); dhit = 1; #1;
        checks++; if (dmemWEN !== 1'b1) begin errors++; $display("FAIL sw_wen_held: got %b expected 1", dmemWEN); end
        @(negedge CLK); dhit = 0; #1;
        checks++; if ({dmemWEN, mem_done} !== 2'b01) begin errors++; $display("FAIL sw_done: got %b expected 01", {dmemWEN, mem_done}); end
        dWEN_mem = 0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        do_reset();
        dWEN_mem = 1; aluout_mem = 64'h4000; funct3_mem = 3'b011; rdata2_mem = 64'hCAFEBABE_01234567;
        #1; dones += int'(mem_done);
        @(negedge CLK); dhit = 1; #1; dones += int'(mem_done);
        checks++; if ({dmemstore, dmembyteen} !== {64'hCAFEBABE_01234567, 8'hFF}) begin errors++; $display("FAIL b2b_sd_store: got %h/%h expected cafebabe01234567/ff", dmemstore, dmembyteen); end
        @(negedge CLK); dhit = 0; #1; dones += int'(mem_done);
        dWEN_mem = 0; dREN_mem = 1; aluout_mem = 64'h4008; dmemload = 64'h01234567_89ABCDEF;
        @(negedge CLK); #1; dones += int'(mem_done);
        checks++; if ({freeze, dmemREN, dmemWEN} !== 3'b100) begin errors++; $display("FAIL b2b_ld_idle: got %b expected 100", {freeze, dmemREN, dmemWEN}); end
        @(negedge CLK); dhit = 1; #1; dones += int'(mem_done);
        checks++; if ({dmemaddr, dmemREN} !== {64'h4008, 1'b1}) begin errors++; $display("FAIL b2b_ld_req: got %h/%b expected 4008/1", dmemaddr, dmemREN); end
        @(negedge CLK); dhit = 0; #1; dones += int'(mem_done);
        checks++; if (mem_load_data !== 64'h01234567_89ABCDEF) begin errors++; $display("FAIL b2b_ld_data: got %h expected 0123456789abcdef", mem_load_data); end
        dREN_mem = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1; dones += int'(mem_done);
            checks++; if ({dmemREN, dmemWEN, freeze} !== 3'b000) begin errors++; $display("FAIL b2b_no_reissue: got %b expected 000", {dmemREN, dmemWEN, freeze}); end
        end
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", dones); end
    endtask

    task automatic test_store_wins();
        do_reset();
        dREN_mem = 1; dWEN_mem = 1; aluout_mem = 64'h6000; funct3_mem = 3'b011; rdata2_mem = 64'h55;
        @(negedge CLK); dhit = 1; dmemload = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        checks++; if ({dmemWEN, dmemREN} !== 2'b10) begin errors++; $display("FAIL both_wen/ren: got %b expected 10", {dmemWEN, dmemREN}); end
        @(negedge CLK); dhit = 0; #1;
        checks++; if ({mem_done, mem_load_data} !== {1'b1, 64'd0}) begin errors++; $display("FAIL both_noload: got %b/%h expected 1/0", mem_done, mem_load_data); end
        dREN_mem = 0; dWEN_mem = 0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        dREN_mem = 1; aluout_mem = 64'h7000; funct3_mem = 3'b011;
        @(negedge CLK); #1;
        checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL rstreq_pre: got %b expected 1", dmemREN); end
        nRST = 0; dREN_mem = 0; #1;
        checks++; if ({dmemREN, freeze, mem_done, stall_cnt} !== 35'd0) begin errors++; $display("FAIL rstreq_drop: got %b/%b/%b/%0d expected 0", dmemREN, freeze, mem_done, stall_cnt); end
        @(negedge CLK); nRST = 1;
        @(negedge CLK); #1;
        checks++; if ({dmemREN, mem_done, stall_cnt} !== 34'd0) begin errors++; $display("FAIL rstreq_idle: got %b/%b/%0d expected 0", dmemREN, mem_done, stall_cnt); end
        dREN_mem = 1; #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL rstreq_reissue_idle: got %b expected 1", freeze); end
        @(negedge CLK); dhit = 1; #1;
        checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL rstreq_reissue_req: got %b expected 1", dmemREN); end
        @(negedge CLK); dhit = 0; dREN_mem = 0;
        @(negedge CLK);
    endtask

    task automatic test_misalign();
        do_reset();
        dREN_mem = 1; aluout_mem = 64'h5002; funct3_mem = 3'b010; dmemload = 64'h12345678_9ABCDEF0;
`ifdef MISALIGN_TRAP_EN
        @(negedge CLK); #1;
        checks++; if ({misalign_trap, mem_done, dmemREN} !== 3'b110) begin errors++; $display("FAIL mis_trap: got %b expected 110", {misalign_trap, mem_done, dmemREN}); end
        checks++; if (mem_load_data !== 64'd0) begin errors++; $display("FAIL mis_data: got %h expected 0", mem_load_data); end
        dREN_mem = 0;
        @(negedge CLK); #1;
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_trap_clear: got %b expected 0", misalign_trap); end
`else
        @(negedge CLK); dhit = 1; #1;
        checks++; if ({dmemaddr, dmemREN} !== {64'h5000, 1'b1}) begin errors++; $display("FAIL mis_addr: got %h/%b expected 5000/1", dmemaddr, dmemREN); end
        @(negedge CLK); dhit = 0; #1;
        checks++; if ({mem_done, mem_load_data} !== {1'b1, 64'hFFFFFFFF_9ABCDEF0}) begin errors++; $display("FAIL mis_data: got %b/%h expected 1/ffffffff9abcdef0", mem_done, mem_load_data); end
        dREN_mem = 0;
        @(negedge CLK);
`endif
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_wait();
        test_sw();
        test_back_to_back();
        test_store_wins();
        test_reset_mid_req();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EXE/MEM latch: takes the MEM-stage control and data outputs and runs the data-cache transaction.
- Consumes dREN_mem, dWEN_mem, aluout_mem, rdata2_mem and funct3_mem.
- Drives the dcache request/handshake, aligns and extends load data, and builds byte-lane store data.
- Asserts freeze back to the pipeline latches until the access completes.

Parameters:
- STALL_CNT_W, 32, width of the saturating MEM-stall cycle counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- dREN_mem  input  1  load in MEM stage.
- dWEN_mem  input  1  store in MEM stage.
- aluout_mem  input  64  effective byte address.
- rdata2_mem  input  64  store source data, in the low bits.
- funct3_mem  input  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- dmemREN  output  1  dcache read request.
- dmemWEN  output  1  dcache write request.
- dmemaddr  output  64  dword-aligned address, {aluout_mem[63:3],3'b0}.
- dmemstore  output  64  lane-shifted store data.
- dmembyteen  output  8  store byte enables.
- dmemload  input  64  dcache read data, valid with dhit.
- dhit  input  1  dcache completion.
- freeze  output  1  stall to the IF/ID, ID/EXE and EXE/MEM latches.
- mem_load_data  output  64  extended load result.
- mem_done  output  1  one-cycle access-complete pulse.
- stall_cnt  output  STALL_CNT_W  saturating count of cycles with freeze high.

Behaviour:
- Reset (async, nRST low): state=IDLE. dmemREN, dmemWEN, dmembyteen, mem_done, freeze all 0; mem_load_data=0; stall_cnt=0; dmemaddr/dmemstore=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If dREN_mem|dWEN_mem, go to REQ next cycle and register address, store lanes, byte enables, funct3 and offset.
  - freeze=1 combinationally in this cycle.
- REQ:
  - dmemREN/dmemWEN are driven from registers and held stable until dhit.
  - freeze=1.
  - On dhit: capture the extended load data into mem_load_data, go to DONE.
  - dhit is ignored in IDLE and DONE.
- DONE:
  - freeze=0, mem_done=1, dmemREN=dmemWEN=0.
  - The EXE/MEM latch advances at the end of this cycle.
  - Always returns to IDLE; the instruction is never re-issued.
- Minimum latency: detect cycle, REQ with immediate dhit, DONE = 3 cycles; each extra dhit wait adds 1.
- dREN_mem and dWEN_mem both high is illegal; the store wins and no load data is updated.
- Offset and size: off=aluout_mem[2:0]; size=1/2/4/8 bytes from funct3[1:0].
- Load result: (dmemload >> 8*off) truncated to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1). LD ignores the extension.
- Store lanes: dmemstore = rdata2_mem[size*8-1:0] << 8*off, other lanes 0.
- Byte enables: dmembyteen = ((1<<size)-1) << off. For loads dmembyteen=0.
- funct3 111: treated as a D access.
- freeze/flush interplay: pipeline flush is not an input. An access already in REQ always completes, since a cache transaction must not be abandoned.
- stall_cnt: increments every cycle freeze=1 and saturates at all-ones, with no wrap.
- Reset mid-REQ: request drops immediately; no mem_done pulse.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_trap (1).
  - A misaligned access (off not a multiple of size) issues no dcache request. IDLE goes directly to DONE, misalign_trap=1 for that DONE cycle, mem_load_data=0, no bytes written.
  - misalign_trap resets to 0.
- Undefined:
  - No port is added.
  - off is forced to natural alignment (off & ~(size-1)) before lane shift, byte-enable and extract.
  - The access proceeds normally.

Test Plan:
- LB at 0x1003, dmemload=0x00000000_80000000, dhit on first REQ cycle -> freeze 1,1,0; mem_done on cycle 3; mem_load_data=0xFFFFFFFF_FFFFFF80; dmemaddr=0x1000.
- LHU at 0x2006 with dmemload=0xBEEF0000_00000000, dhit delayed 4 cycles -> dmemREN held 5 cycles, mem_load_data=0x0000_0000_0000_BEEF, stall_cnt=6.
- SW at 0x3004, rdata2_mem=0x11223344_DEADBEEF -> dmemstore=0xDEADBEEF_00000000, dmembyteen=0xF0, dmemWEN held until dhit.
- SD at 0x4000 then back-to-back LD at 0x4008 -> two complete 3-cycle sequences, exactly two mem_done pulses, no re-issue.
- nRST pulled low in REQ while dhit is low -> outputs go to 0 immediately; after release the FSM is in IDLE and stall_cnt=0.
- LW at 0x5002: with MISALIGN_TRAP_EN -> misalign_trap=1 with no dmemREN. Without it -> access at lane offset 0, dmemaddr=0x5000.
